div3_serial: RTL and testbench



---
 rtl/div3_pkg.sv | 20 ++
 rtl/div3_step.sv | 28 ++
 rtl/div3_serial.sv | 135 +++++++++++++
 tb/tb_div3_serial.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div3_pkg.sv
// div3_pkg: shared types and constants for the bit-serial divide-by-3 block.
//   state_e   : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//   REM_W     : width of the running remainder r (values 0..2)
//   cnt_width : helper giving the bit-counter width for a given operand width
package div3_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned REM_W = 2;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div3_step.sv
// div3_step: one step of the MSB-first divide-by-3 remainder recurrence.
//   r      : current remainder (0..2; the 2'b11 encoding is treated as 0)
//   b      : next dividend bit
//   q      : quotient bit, 1 when 2r+b >= 3
//   r_next : next remainder, 2r+b-3q
module div3_step
  import div3_pkg::*;
(
  input  logic [REM_W-1:0] r,
  input  logic             b,
  output logic             q,
  output logic [REM_W-1:0] r_next
);

  logic [REM_W-1:0] r_eff;
  logic [2:0]       t;
  logic [2:0]       t_sub;

  always_comb begin
    // Unreachable 2'b11 is folded to 0 so a corrupted remainder self-heals.
    r_eff  = (r == 2'b11) ? 2'b00 : r;
    t      = {r_eff, b};
    t_sub  = t - 3'd3;
    q      = (t >= 3'd3);
    r_next = q ? t_sub[1:0] : t[1:0];
  end

endmodule

// File: rtl/div3_serial.sv
// div3_serial: bit-serial unsigned divider by the constant 3, one bit per clock, MSB first.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : operand handshake, in_data is the WIDTH-bit dividend
//   out_valid/out_ready : result handshake
//   quot                : floor(in_data/3), WIDTH-1 bits (the quotient MSB is always 0)
//   rem                 : in_data mod 3
//   exact               : 1 when rem == 0
//   busy                : 1 whenever the FSM is not idle
//   chk_err             : sticky reconstruction error, present only with DIV3_SELFCHECK_EN
module div3_serial
  import div3_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-2:0] quot,
  output logic [REM_W-1:0] rem,
  output logic             exact,
  output logic             busy
`ifdef DIV3_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so after
  // WIDTH shifts this register holds the full quotient.
  logic [WIDTH-1:0] work_q, work_d;
  logic [REM_W-1:0] r_q, r_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             exact_q, exact_d;
  logic             step_q;
  logic [REM_W-1:0] step_r;
  logic             last;
  logic             enter_done;

  div3_step u_step (
    .r      (r_q),
    .b      (work_q[WIDTH-1]),
    .q      (step_q),
    .r_next (step_r)
  );

  assign last       = (cnt_q == CntW'(WIDTH - 1));
  assign enter_done = (state_q == StShift) && last;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    exact_d = exact_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          work_d  = in_data;
          r_d     = '0;
          cnt_d   = '0;
          exact_d = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        work_d = {work_q[WIDTH-2:0], step_q};
        r_d    = step_r;
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          exact_d = (step_r == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      exact_q <= exact_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign quot      = work_q[WIDTH-2:0];
  assign rem       = r_q;
  assign exact     = exact_q;

`ifdef DIV3_SELFCHECK_EN
  logic [WIDTH-1:0] op_q;
  logic             chk_err_q;
  logic [WIDTH+1:0] recon;

  // 3*quot + rem computed as quot + 2*quot + rem from the values entering DONE.
  assign recon = {2'b00, work_d} + {1'b0, work_d, 1'b0} + (WIDTH + 2)'(r_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if ((state_q == StIdle) && in_valid) op_q <= in_data;
      if (enter_done && (recon != {2'b00, op_q})) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  logic unused_enter_done;
  assign unused_enter_done = enter_done;
`endif

endmodule

// File: tb/tb_div3_serial.sv
// tb_div3_serial: self-checking bench for div3_serial at WIDTH=6 and WIDTH=4.
// Expected results come from plain integer division and modulo of the operand.
module tb_div3_serial;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       iv6, ir6, ov6, or6, ex6, bz6;
  logic [5:0] id6;
  logic [4:0] q6;
  logic [1:0] r6;

  logic       iv4, ir4, ov4, or4, ex4, bz4;
  logic [3:0] id4;
  logic [2:0] q4;
  logic [1:0] r4;

`ifdef DIV3_SELFCHECK_EN
  logic       ce6, ce4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div3_serial #(.WIDTH(6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv6),
    .in_ready  (ir6),
    .in_data   (id6),
    .out_valid (ov6),
    .out_ready (or6),
    .quot      (q6),
    .rem       (r6),
    .exact     (ex6),
    .busy      (bz6)
`ifdef DIV3_SELFCHECK_EN
    ,
    .chk_err   (ce6)
`endif
  );

  div3_serial #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .in_data   (id4),
    .out_valid (ov4),
    .out_ready (or4),
    .quot      (q4),
    .rem       (r4),
    .exact     (ex4),
    .busy      (bz4)
`ifdef DIV3_SELFCHECK_EN
    ,
    .chk_err   (ce4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One WIDTH=6 transaction: accept x, measure latency, check result, stall, hand off.
  task automatic xact6(input int x, input int stall, input bit inject);
    int n;
    n = 0;
    while (!ir6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w6_in_ready", 32'(ir6), 1);
    iv6 = 1'b1;
    id6 = 6'(x);
    @(posedge clk);
    #1;
    iv6 = 1'b0;
    id6 = 6'($urandom);
    n = 0;
    while (!ov6 && n < 100) begin
      if (inject && n == 2) begin
        iv6 = 1'b1;
        id6 = 6'd9;
      end
      @(posedge clk);
      #1;
      iv6 = 1'b0;
      n++;
    end
    check("w6_latency", n, 6);
    check("w6_quot", 32'(q6), x / 3);
    check("w6_rem", 32'(r6), x % 3);
    check("w6_exact", 32'(ex6), (x % 3 == 0) ? 1 : 0);
    check("w6_busy_done", 32'(bz6), 1);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("w6_stall_valid", 32'(ov6), 1);
      check("w6_stall_quot", 32'(q6), x / 3);
      check("w6_stall_rem", 32'(r6), x % 3);
      check("w6_stall_in_ready", 32'(ir6), 0);
    end
    or6 = 1'b1;
    @(posedge clk);
    #1;
    or6 = 1'b0;
    check("w6_after_hs_valid", 32'(ov6), 0);
    check("w6_after_hs_in_ready", 32'(ir6), 1);
    check("w6_after_hs_busy", 32'(bz6), 0);
  endtask

  task automatic xact4(input int x, input int stall);
    int n;
    n = 0;
    while (!ir4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("w4_in_ready", 32'(ir4), 1);
    iv4 = 1'b1;
    id4 = 4'(x);
    @(posedge clk);
    #1;
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w4_latency", n, 4);
    repeat (stall) @(posedge clk);
    #1;
    check("w4_valid", 32'(ov4), 1);
    check("w4_quot", 32'(q4), x / 3);
    check("w4_rem", 32'(r4), x % 3);
    check("w4_exact", 32'(ex4), (x % 3 == 0) ? 1 : 0);
    or4 = 1'b1;
    @(posedge clk);
    #1;
    or4 = 1'b0;
    check("w4_after_hs_valid", 32'(ov4), 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x;
    rst_n = 1'b0;
    iv6 = 1'b0; id6 = '0; or6 = 1'b0;
    iv4 = 1'b0; id4 = '0; or4 = 1'b0;
    #12;
    check("rst_in_ready", 32'(ir6), 1);
    check("rst_out_valid", 32'(ov6), 0);
    check("rst_busy", 32'(bz6), 0);
    check("rst_quot", 32'(q6), 0);
    check("rst_rem", 32'(r6), 0);
    check("rst_exact", 32'(ex6), 0);
    rst_n = 1'b1;
    @(negedge clk);

    xact6(63, 0, 1'b0);
    xact6(44, 0, 1'b0);
    xact6(0, 0, 1'b0);
    xact6(40, 10, 1'b0);
    xact6(30, 0, 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("w6_no_extra_valid", 32'(ov6), 0);
    end

    // Reset in the middle of SHIFT for operand 50.
    @(negedge clk);
    iv6 = 1'b1;
    id6 = 6'd50;
    @(posedge clk);
    #1;
    iv6 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_before_rst", 32'(bz6), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ov6), 0);
    check("mid_rst_busy", 32'(bz6), 0);
    check("mid_rst_in_ready", 32'(ir6), 1);
    check("mid_rst_quot", 32'(q6), 0);
    check("mid_rst_rem", 32'(r6), 0);
    check("mid_rst_exact", 32'(ex6), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      check("post_rst_no_valid", 32'(ov6), 0);
    end
    xact6(7, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      x = int'($urandom_range(0, 63));
      xact6(x, int'($urandom_range(0, 3)), 1'b0);
    end

    for (int v = 0; v < 16; v++) xact4(v, int'($urandom_range(0, 3)));

`ifdef DIV3_SELFCHECK_EN
    check("chk_err6", 32'(ce6), 0);
    check("chk_err4", 32'(ce4), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
